fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_pkg.sv | 16 +
 rtl/fetch_queue.sv | 72 +++++++
 tb/tb_fetch_queue.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared CPU constants and types: reset vector, MROM window, fetch queue sizing and entry format.
package fetch_queue_pkg;

    localparam logic [31:0] RESET_PC  = 32'h8000_0000;
    localparam logic [31:0] MROM_BASE = 32'h8000_0000;
    localparam int unsigned MROM_SIZE = 4096;

    localparam int unsigned FQ_DEPTH   = 4;
    localparam int unsigned FQ_ENTRY_W = 64;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Show-ahead instruction fetch queue between fetch and decode, with redirect flush.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = FQ_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fq_i_valid,
    input  logic [31:0]              fq_i_pc,
    input  logic [31:0]              fq_i_instr,
    output logic                     fq_o_ready,
    output logic                     fq_o_valid,
    output logic [31:0]              fq_o_pc,
    output logic [31:0]              fq_o_instr,
    input  logic                     fq_i_dec_ready,
    input  logic                     fq_i_flush,
    output logic [$clog2(DEPTH):0]   fq_o_count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    fq_entry_t          mem_q [DEPTH];
    logic [PtrW-1:0]    head_q;
    logic [PtrW-1:0]    tail_q;
    logic [CntW-1:0]    count_q;
    logic               push;
    logic               pop;

    // Ready and valid depend on registered occupancy only, so no combinational path from inputs.
    assign fq_o_ready = (count_q < CntW'(DEPTH));
    assign fq_o_valid = (count_q != '0);
    assign fq_o_count = count_q;

    assign push = fq_i_valid && fq_o_ready && !fq_i_flush;
    assign pop  = fq_o_valid && fq_i_dec_ready && !fq_i_flush;

    // Stale entries survive a flush, so the head must be masked when empty.
    assign fq_o_pc    = fq_o_valid ? mem_q[head_q].pc    : 32'h0;
    assign fq_o_instr = fq_o_valid ? mem_q[head_q].instr : 32'h0;

    // Pointers are PtrW wide, so advancing them wraps modulo DEPTH for free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (fq_i_flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem_q[tail_q] <= '{pc: fq_i_pc, instr: fq_i_instr};
                tail_q        <= tail_q + PtrW'(1);
            end
            if (pop) begin
                head_q <= head_q + PtrW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CntW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus random traffic against a queue model.
module tb_fetch_queue;

    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        fq_i_valid;
    logic [31:0] fq_i_pc;
    logic [31:0] fq_i_instr;
    logic        fq_o_ready;
    logic        fq_o_valid;
    logic [31:0] fq_o_pc;
    logic [31:0] fq_o_instr;
    logic        fq_i_dec_ready;
    logic        fq_i_flush;
    logic [$clog2(DEPTH):0] fq_o_count;

    int n_assert = 0;
    int n_fail   = 0;

    logic [63:0] mq [$];

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .fq_i_valid     (fq_i_valid),
        .fq_i_pc        (fq_i_pc),
        .fq_i_instr     (fq_i_instr),
        .fq_o_ready     (fq_o_ready),
        .fq_o_valid     (fq_o_valid),
        .fq_o_pc        (fq_o_pc),
        .fq_o_instr     (fq_o_instr),
        .fq_i_dec_ready (fq_i_dec_ready),
        .fq_i_flush     (fq_i_flush),
        .fq_o_count     (fq_o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] exp_pc;
        logic [31:0] exp_ins;
        exp_pc  = (mq.size() != 0) ? mq[0][63:32] : 32'h0;
        exp_ins = (mq.size() != 0) ? mq[0][31:0]  : 32'h0;
        check({tag, ".valid"}, 64'(fq_o_valid), 64'(mq.size() != 0));
        check({tag, ".ready"}, 64'(fq_o_ready), 64'(mq.size() < DEPTH));
        check({tag, ".count"}, 64'(fq_o_count), 64'(mq.size()));
        check({tag, ".pc"},    64'(fq_o_pc),    64'(exp_pc));
        check({tag, ".instr"}, 64'(fq_o_instr), 64'(exp_ins));
    endtask

    // One clock: drive inputs, apply the queue rules to the model, then compare.
    task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                         input logic dr, input logic fl, input string tag);
        logic do_push;
        logic do_pop;
        fq_i_valid     = v;
        fq_i_pc        = pc;
        fq_i_instr     = ins;
        fq_i_dec_ready = dr;
        fq_i_flush     = fl;
        do_push = v && !fl && (mq.size() < DEPTH);
        do_pop  = dr && !fl && (mq.size() != 0);
        @(posedge clk);
        if (fl) begin
            mq.delete();
        end else begin
            if (do_pop)  mq.delete(0);
            if (do_push) mq.push_back({pc, ins});
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        rst            = 1'b1;
        fq_i_valid     = 1'b0;
        fq_i_pc        = '0;
        fq_i_instr     = '0;
        fq_i_dec_ready = 1'b0;
        fq_i_flush     = 1'b0;
        #12;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Single pass through the queue.
        cycle(1'b1, 32'h8000_0000, 32'h0000_0413, 1'b1, 1'b0, "single_push");
        check("single_pc", 64'(fq_o_pc), 64'h8000_0000);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "single_pop");
        check("single_empty", 64'(fq_o_valid), 64'h0);

        // Fill, refuse a fifth push, drain in order.
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 32'h8000_0000 + 32'(4 * k), 32'h1000 + 32'(k), 1'b0, 1'b0, "fill");
        end
        check("fill_count", 64'(fq_o_count), 64'd4);
        check("fill_ready", 64'(fq_o_ready), 64'h0);
        cycle(1'b1, 32'h8000_0010, 32'hdead, 1'b0, 1'b0, "fill_refuse");

        // Full with simultaneous pop: only the pop happens.
        cycle(1'b1, 32'h8000_0020, 32'hbeef, 1'b1, 1'b0, "full_pop");
        check("full_pop_count", 64'(fq_o_count), 64'd3);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "drain");
        end

        // Back-to-back push+pop across pointer wrap.
        cycle(1'b1, 32'h8000_0000, 32'h2000, 1'b0, 1'b0, "wrap_prime");
        for (int k = 1; k <= 10; k++) begin
            cycle(1'b1, 32'h8000_0000 + 32'(4 * k), 32'h2000 + 32'(k), 1'b1, 1'b0, "wrap");
        end
        check("wrap_count", 64'(fq_o_count), 64'd1);
        cycle(1'b1, 32'h8000_0030, 32'h3000, 1'b0, 1'b0, "pre_flush");
        cycle(1'b1, 32'h8000_0034, 32'h3001, 1'b0, 1'b0, "pre_flush");

        // Flush with a same-cycle push that must be dropped.
        cycle(1'b1, 32'h8000_0100, 32'h4000, 1'b1, 1'b1, "flush");
        check("flush_valid", 64'(fq_o_valid), 64'h0);
        cycle(1'b1, 32'h8000_0200, 32'h5000, 1'b0, 1'b0, "post_flush");
        check("post_flush_pc", 64'(fq_o_pc), 64'h8000_0200);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, "flush2");
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, "flush_empty");

        // Asynchronous reset between edges.
        cycle(1'b1, 32'h8000_0300, 32'h6000, 1'b0, 1'b0, "pre_rst");
        cycle(1'b1, 32'h8000_0304, 32'h6001, 1'b0, 1'b0, "pre_rst");
        #2;
        rst = 1'b1;
        #1;
        mq.delete();
        check_all("async_rst");
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, 32'h8000_0400, 32'h7000, 1'b0, 1'b0, "post_rst_push");

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            cycle(($urandom % 4) != 0, $urandom, $urandom, ($urandom % 2) == 1,
                  ($urandom % 20) == 0, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
